// File: rtl/spi_ram_master.sv
// spi_ram_master
//   Host-side SPI master that turns one host request into a complete RAM
//   transaction on the SPI bus. Every request becomes two frames. The address
//   frame goes first and the data frame follows it. A read-data frame is
//   extended by an optional wait and then an 8-bit receive phase on MISO. Each
//   frame, including the last one, is followed by GAP_CYC cycles with SS_n
//   high.
//
//   Parameters
//     GAP_CYC   cycles SS_n is held high after every frame (>= 1)
//     MISO_DLY  idle cycles between the last MOSI bit of a read-data frame
//               and the first MISO data bit (>= 0)
//
//   Ports
//     clk, rst_n   clock (posedge), asynchronous active-low reset
//     req_valid    host request valid
//     req_ready    idle, a request presented now is accepted
//     req_rw       0 = write, 1 = read
//     req_addr     RAM address
//     req_wdata    write byte (ignored for reads)
//     rsp_valid    one-cycle pulse when a request completes
//     rsp_rdata    last byte read; only reads update it
//     busy         !req_ready
//     SS_n, MOSI   slave select (active low) and serial data out
//     MISO         serial data in

module spi_ram_master #(
    parameter int unsigned GAP_CYC  = 1,
    parameter int unsigned MISO_DLY = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rw,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       busy,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO
);

    localparam int unsigned GapW  = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam int unsigned WaitW = (MISO_DLY > 1) ? $clog2(MISO_DLY) : 1;
    localparam logic [GapW-1:0]  GapLast  = GapW'(GAP_CYC - 1);
    // Never compared when MISO_DLY is 0: RD_WAIT is skipped entirely then.
    localparam logic [WaitW-1:0] WaitLast = WaitW'(MISO_DLY - 1);

    typedef enum logic [2:0] {
        StIdle,
        StFrame,
        StGap,
        StRdWait,
        StRdRecv
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        bit_cnt_q;     // frame bit F0..F10
    logic [2:0]        rx_cnt_q;      // receive bit 0..7
    logic [WaitW-1:0]  wait_cnt_q;
    logic [GapW-1:0]   gap_cnt_q;
    logic              data_phase_q;  // 0: address frame, 1: data frame
    logic              rw_q;
    logic [7:0]        addr_q;
    logic [7:0]        wdata_q;
    logic [6:0]        rx_shift_q;
    logic [7:0]        rdata_q;

    logic [7:0]        frame_byte;
    logic [10:0]       frame_word;

    // Read-data frames carry no payload, so the byte field is sent as zero.
    assign frame_byte = data_phase_q ? (rw_q ? 8'h00 : wdata_q) : addr_q;
    // Bit 10 is the F0 mode bit (c[1]), bits 9..0 are {code, byte} MSB first.
    assign frame_word = {rw_q, rw_q, data_phase_q, frame_byte};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) state_d = StFrame;
            end
            StFrame: begin
                if (bit_cnt_q == 4'd10) begin
                    if (data_phase_q && rw_q) begin
                        state_d = (MISO_DLY == 0) ? StRdRecv : StRdWait;
                    end else begin
                        state_d = StGap;
                    end
                end
            end
            StRdWait: begin
                if (wait_cnt_q == WaitLast) state_d = StRdRecv;
            end
            StRdRecv: begin
                if (rx_cnt_q == 3'd7) state_d = StGap;
            end
            StGap: begin
                if (gap_cnt_q == GapLast) state_d = data_phase_q ? StIdle : StFrame;
            end
            default: state_d = StIdle;
        endcase
    end

    // Counters, request capture and receive shifter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q    <= 4'd0;
            rx_cnt_q     <= 3'd0;
            wait_cnt_q   <= '0;
            gap_cnt_q    <= '0;
            data_phase_q <= 1'b0;
            rw_q         <= 1'b0;
            addr_q       <= 8'h00;
            wdata_q      <= 8'h00;
            rx_shift_q   <= 7'h00;
            rdata_q      <= 8'h00;
        end else begin
            // Each counter runs only in its own state and is zero on entry.
            bit_cnt_q  <= (state_q == StFrame && bit_cnt_q != 4'd10) ?
                          bit_cnt_q + 4'd1 : 4'd0;
            gap_cnt_q  <= (state_q == StGap && gap_cnt_q != GapLast) ?
                          gap_cnt_q + GapW'(1) : '0;
            wait_cnt_q <= (state_q == StRdWait && wait_cnt_q != WaitLast) ?
                          wait_cnt_q + WaitW'(1) : '0;
            rx_cnt_q   <= (state_q == StRdRecv) ? rx_cnt_q + 3'd1 : 3'd0;

            if (state_q == StIdle && req_valid) begin
                rw_q         <= req_rw;
                addr_q       <= req_addr;
                wdata_q      <= req_wdata;
                data_phase_q <= 1'b0;
            end else if (state_q == StGap && state_d == StFrame) begin
                data_phase_q <= 1'b1;
            end

            if (state_q == StRdRecv) begin
                rx_shift_q <= {rx_shift_q[5:0], MISO};
                if (rx_cnt_q == 3'd7) rdata_q <= {rx_shift_q, MISO};
            end
        end
    end

    // Outputs, decoded from registered state only
    always_comb begin
        SS_n      = 1'b1;
        MOSI      = 1'b0;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        unique case (state_q)
            StIdle: req_ready = 1'b1;
            StFrame: begin
                SS_n = 1'b0;
                MOSI = frame_word[4'd10 - bit_cnt_q];
            end
            StRdWait, StRdRecv: SS_n = 1'b0;
            // Completion pulse: first cycle of the gap after the data frame.
            StGap: rsp_valid = data_phase_q && (gap_cnt_q == '0);
            default: ;
        endcase
    end

    assign busy      = ~req_ready;
    assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_spi_ram_master.sv
// Bench for spi_ram_master: two instances (GAP_CYC=1/MISO_DLY=1 and
// GAP_CYC=3/MISO_DLY=0), a cycle timeline model built per accepted request,
// a bench-side RAM feeding MISO, directed literal checks, then random traffic.

module tb_spi_ram_master;

    localparam int G0 = 1;
    localparam int D0 = 1;
    localparam int G1 = 3;
    localparam int D1 = 0;
    localparam int MaxLen = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic       req_valid [2];
    logic       req_rw    [2];
    logic [7:0] req_addr  [2];
    logic [7:0] req_wdata [2];
    logic       miso      [2];
    logic       req_ready [2];
    logic       rsp_valid [2];
    logic [7:0] rsp_rdata [2];
    logic       busy      [2];
    logic       ss_n      [2];
    logic       mosi      [2];

    always #5 clk = ~clk;

    spi_ram_master #(.GAP_CYC(G0), .MISO_DLY(D0)) u_dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid[0]),
        .req_ready (req_ready[0]),
        .req_rw    (req_rw[0]),
        .req_addr  (req_addr[0]),
        .req_wdata (req_wdata[0]),
        .rsp_valid (rsp_valid[0]),
        .rsp_rdata (rsp_rdata[0]),
        .busy      (busy[0]),
        .SS_n      (ss_n[0]),
        .MOSI      (mosi[0]),
        .MISO      (miso[0])
    );

    spi_ram_master #(.GAP_CYC(G1), .MISO_DLY(D1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid[1]),
        .req_ready (req_ready[1]),
        .req_rw    (req_rw[1]),
        .req_addr  (req_addr[1]),
        .req_wdata (req_wdata[1]),
        .rsp_valid (rsp_valid[1]),
        .rsp_rdata (rsp_rdata[1]),
        .busy      (busy[1]),
        .SS_n      (ss_n[1]),
        .MOSI      (mosi[1]),
        .MISO      (miso[1])
    );

    // Expected per-cycle timeline of the transaction in flight, per lane.
    // Entry 0 is the cycle right after the accepting edge.
    bit         tl_ss    [2][MaxLen];
    bit         tl_mosi  [2][MaxLen];
    bit         tl_rsp   [2][MaxLen];
    bit         tl_miso  [2][MaxLen];
    bit         tl_hasrd [2][MaxLen];
    logic [7:0] tl_rd    [2][MaxLen];
    int         len [2] = '{0, 0};
    int         pos [2] = '{0, 0};
    logic [7:0] mem [2][256];
    logic [7:0] exp_rdata [2] = '{8'h00, 8'h00};

    int vectors     = 0;
    int miscompares = 0;

    function automatic int gap_of(input int l);
        return (l == 0) ? G0 : G1;
    endfunction

    function automatic int dly_of(input int l);
        return (l == 0) ? D0 : D1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic push(input int l, input bit ss, input bit mo, input bit rsp,
                        input bit mi, input bit hr, input logic [7:0] rd);
        tl_ss[l][len[l]]    = ss;
        tl_mosi[l][len[l]]  = mo;
        tl_rsp[l][len[l]]   = rsp;
        tl_miso[l][len[l]]  = mi;
        tl_hasrd[l][len[l]] = hr;
        tl_rd[l][len[l]]    = rd;
        len[l]++;
    endtask

    // Mode bit c[1], then {c, b} MSB first.
    task automatic push_frame(input int l, input logic [1:0] code, input logic [7:0] b);
        logic [9:0] word;
        word = {code, b};
        push(l, 1'b0, code[1], 1'b0, 1'($urandom), 1'b0, 8'h00);
        for (int i = 9; i >= 0; i--) push(l, 1'b0, word[i], 1'b0, 1'($urandom), 1'b0, 8'h00);
    endtask

    task automatic build(input int l, input bit rw, input logic [7:0] a, input logic [7:0] wd);
        logic [7:0] rd;
        len[l] = 0;
        pos[l] = 0;
        rd = mem[l][a];
        if (!rw) mem[l][a] = wd;
        push_frame(l, {rw, 1'b0}, a);
        for (int i = 0; i < gap_of(l); i++) push(l, 1'b1, 1'b0, 1'b0, 1'($urandom), 1'b0, 8'h00);
        push_frame(l, {rw, 1'b1}, rw ? 8'h00 : wd);
        if (rw) begin
            for (int i = 0; i < dly_of(l); i++)
                push(l, 1'b0, 1'b0, 1'b0, 1'($urandom), 1'b0, 8'h00);
            for (int k = 0; k < 8; k++) push(l, 1'b0, 1'b0, 1'b0, rd[7-k], 1'b0, 8'h00);
        end
        for (int i = 0; i < gap_of(l); i++)
            push(l, 1'b1, 1'b0, i == 0, 1'($urandom), (i == 0) && rw, rd);
    endtask

    // Model: advance the timeline or accept a new request on each edge.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            for (int l = 0; l < 2; l++) begin
                if (!rst_n) begin
                    len[l] = 0;
                    pos[l] = 0;
                end else if (len[l] > 0) begin
                    pos[l]++;
                    if (pos[l] >= len[l]) begin
                        len[l] = 0;
                        pos[l] = 0;
                    end
                end else if (req_valid[l]) begin
                    build(l, req_rw[l], req_addr[l], req_wdata[l]);
                end
            end
        end
    end

    // Compare on every falling edge; also drives MISO for the coming edge.
    initial begin
        forever begin
            @(negedge clk);
            for (int l = 0; l < 2; l++) begin
                bit e_ss, e_mo, e_rsp, e_mi, e_rdy;
                e_ss  = 1'b1;
                e_mo  = 1'b0;
                e_rsp = 1'b0;
                e_mi  = 1'($urandom);
                e_rdy = (len[l] == 0);
                if (len[l] > 0) begin
                    e_ss  = tl_ss[l][pos[l]];
                    e_mo  = tl_mosi[l][pos[l]];
                    e_rsp = tl_rsp[l][pos[l]];
                    e_mi  = tl_miso[l][pos[l]];
                    if (tl_hasrd[l][pos[l]]) exp_rdata[l] = tl_rd[l][pos[l]];
                end
                if (!rst_n) exp_rdata[l] = 8'h00;
                miso[l] = e_mi;
                chk($sformatf("ss_n[%0d]", l), ss_n[l], e_ss);
                chk($sformatf("mosi[%0d]", l), mosi[l], e_mo);
                chk($sformatf("req_ready[%0d]", l), req_ready[l], e_rdy);
                chk($sformatf("busy[%0d]", l), busy[l], !e_rdy);
                chk($sformatf("rsp_valid[%0d]", l), rsp_valid[l], e_rsp);
                chk($sformatf("rsp_rdata[%0d]", l), rsp_rdata[l], exp_rdata[l]);
            end
        end
    end

    task automatic wait_idle(input int l);
        int n;
        n = 0;
        @(negedge clk);
        while (len[l] != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("idle_ready", req_ready[l], 1);
    endtask

    // Presents a request while idle; returns just after the accepting edge T,
    // so the k-th following negedge is cycle T+k.
    task automatic issue(input int l, input bit rw, input logic [7:0] a,
                         input logic [7:0] wd, input bit keep);
        wait_idle(l);
        req_valid[l] = 1'b1;
        req_rw[l]    = rw;
        req_addr[l]  = a;
        req_wdata[l] = wd;
        @(posedge clk);
        #1;
        if (!keep) req_valid[l] = 1'b0;
    endtask

    logic [10:0] f1, f2;
    int lo, hi;

    initial begin
        for (int l = 0; l < 2; l++) begin
            req_valid[l] = 1'b0;
            req_rw[l]    = 1'b0;
            req_addr[l]  = 8'h00;
            req_wdata[l] = 8'h00;
            miso[l]      = 1'b0;
            for (int a = 0; a < 256; a++) mem[l][a] = 8'($urandom);
        end
        mem[0][8'hC3] = 8'hA5;
        mem[0][8'h10] = 8'h69;
        mem[1][8'h7E] = 8'h3C;

        // Reset held: toggling req_valid must not start anything.
        repeat (6) begin
            @(negedge clk);
            req_valid[0] = ~req_valid[0];
            req_valid[1] = ~req_valid[1];
            req_addr[0]  = 8'($urandom);
        end
        chk("rst_ss_n", ss_n[0], 1);
        chk("rst_mosi", mosi[0], 0);
        chk("rst_ready", req_ready[0], 1);
        chk("rst_rdata", rsp_rdata[0], 8'h00);
        req_valid[0] = 1'b0;
        req_valid[1] = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Write 0x3A <= 0x5C, G=1
        issue(0, 1'b0, 8'h3A, 8'h5C, 1'b0);
        lo = 0;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            if (k <= 11) f1[11-k] = mosi[0];
            if (k >= 13 && k <= 23) f2[23-k] = mosi[0];
            if ((k <= 11) || (k >= 13 && k <= 23)) lo += (ss_n[0] == 1'b0) ? 1 : 0;
            if (k == 12) chk("wr_gap_ss", ss_n[0], 1);
            if (k == 24) begin
                chk("wr_rsp", rsp_valid[0], 1);
                chk("wr_ready_lo", req_ready[0], 0);
            end
            if (k == 25) begin
                chk("wr_ready", req_ready[0], 1);
                chk("wr_rsp_once", rsp_valid[0], 0);
            end
        end
        chk("wr_frame1", f1, 11'b00000111010);
        chk("wr_frame2", f2, 11'b00101011100);
        chk("wr_ss_low", lo, 22);

        // Read 0xC3 -> 0xA5, G=1 D=1
        issue(0, 1'b1, 8'hC3, 8'h00, 1'b0);
        for (int k = 1; k <= 34; k++) begin
            @(negedge clk);
            if (k == 32) chk("rd_rsp_early", rsp_valid[0], 0);
            if (k == 33) begin
                chk("rd_rsp", rsp_valid[0], 1);
                chk("rd_rdata", rsp_rdata[0], 8'hA5);
            end
            if (k == 34) chk("rd_ready", req_ready[0], 1);
        end

        // Back-to-back: read 0x10, then write 0x11 <= 0xFF with valid held
        issue(0, 1'b1, 8'h10, 8'h00, 1'b1);
        req_rw[0]    = 1'b0;
        req_addr[0]  = 8'h11;
        req_wdata[0] = 8'hFF;
        for (int k = 1; k <= 34; k++) begin
            @(negedge clk);
            if (k == 33) chk("b2b_rdata", rsp_rdata[0], 8'h69);
            if (k == 34) begin
                chk("b2b_ready", req_ready[0], 1);
                chk("b2b_gap_ss", ss_n[0], 1);
            end
        end
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        @(negedge clk);
        chk("b2b_accept_ss", ss_n[0], 0);
        chk("b2b_accept_rdy", req_ready[0], 0);
        wait_idle(0);
        chk("b2b_rdata_kept", rsp_rdata[0], 8'h69);
        issue(0, 1'b1, 8'h11, 8'h00, 1'b0);
        wait_idle(0);
        chk("b2b_readback", rsp_rdata[0], 8'hFF);

        // Reset at F5 of the read-data frame
        issue(0, 1'b1, 8'h55, 8'h00, 1'b0);
        repeat (18) @(negedge clk);
        chk("mid_ss_before", ss_n[0], 0);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_ss_async", ss_n[0], 1);
        chk("mid_mosi_async", mosi[0], 0);
        chk("mid_rsp", rsp_valid[0], 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        issue(0, 1'b1, 8'hC3, 8'h00, 1'b0);
        for (int k = 1; k <= 33; k++) begin
            @(negedge clk);
            if (k == 33) begin
                chk("post_rst_rsp", rsp_valid[0], 1);
                chk("post_rst_rdata", rsp_rdata[0], 8'hA5);
            end
        end

        // Lane 1 (G=3, D=0): read 0x7E -> 0x3C
        issue(1, 1'b1, 8'h7E, 8'h00, 1'b0);
        hi = 0;
        for (int k = 1; k <= 35; k++) begin
            @(negedge clk);
            if (k >= 12 && k <= 14) hi += (ss_n[1] == 1'b1) ? 1 : 0;
            if (k == 15) chk("g3_frame2_start", ss_n[1], 0);
            if (k == 34) begin
                chk("g3_rsp", rsp_valid[1], 1);
                chk("g3_rdata", rsp_rdata[1], 8'h3C);
            end
        end
        chk("g3_gap_len", hi, 3);

        // Random traffic on both lanes, narrow address range, rare resets
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            for (int l = 0; l < 2; l++) begin
                req_valid[l] = (($urandom % 4) != 0);
                req_rw[l]    = 1'($urandom);
                req_addr[l]  = 8'($urandom % 16);
                req_wdata[l] = 8'($urandom);
            end
            if (($urandom % 1500) == 0) begin
                #1 rst_n = 1'b0;
                repeat (2) @(posedge clk);
                #2 rst_n = 1'b1;
            end
        end
        req_valid[0] = 1'b0;
        req_valid[1] = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
